// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier and restoring divider that write internal HI/LO.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_con_Valid,
    output logic             o_con_Ready,
    input  logic [1:0]       i_con_AluOp,
    input  logic [5:0]       i_con_FuncCode,
    input  logic [WIDTH-1:0] i_dat_A,
    input  logic [WIDTH-1:0] i_dat_B,
    input  logic [SH_W-1:0]  i_dat_Shamt,
    output logic             o_con_Valid,
    output logic [WIDTH-1:0] o_dat_Result,
    output logic             o_con_Zero,
    output logic             o_con_Ovf,
    output logic             o_con_Illegal,
    output logic [WIDTH-1:0] o_dat_Hi,
    output logic [WIDTH-1:0] o_dat_Lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [SH_W:0] CNT_LAST = (SH_W+1)'(WIDTH);
    localparam logic [SH_W:0] CNT_ONE  = {{SH_W{1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    state_t           state_q;
    logic [SH_W:0]    cnt_q;
    logic             valid_q, zero_q, ovf_q, illegal_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic [WIDTH-1:0] op_a_q, op_b_q, opnd_q, work_hi_q, work_lo_q;
    logic             op_signed_q, neg_lo_q, neg_hi_q, op_mul_q;

    logic [WIDTH-1:0] work_hi_d, work_lo_d;
    logic [WIDTH-1:0] sum_s, diff_s, sc_result_s;
    logic             sc_ovf_s, illegal_s, is_mul_s, is_div_s, is_signed_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic             div_ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

    assign sum_s  = i_dat_A + i_dat_B;
    assign diff_s = i_dat_A - i_dat_B;

    // Decode AluOp/funct and compute every single-cycle result.
    always_comb begin
        sc_result_s = '0;
        sc_ovf_s    = 1'b0;
        illegal_s   = 1'b0;
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        case (i_con_AluOp)
            2'b00: sc_result_s = sum_s;
            2'b01: sc_result_s = diff_s;
            2'b10: begin
                case (i_con_FuncCode)
                    6'd0:  sc_result_s = i_dat_B << i_dat_Shamt;
                    6'd2:  sc_result_s = i_dat_B >> i_dat_Shamt;
                    6'd3:  sc_result_s = $signed(i_dat_B) >>> i_dat_Shamt;
                    6'd4:  sc_result_s = i_dat_B << i_dat_A[SH_W-1:0];
                    6'd6:  sc_result_s = i_dat_B >> i_dat_A[SH_W-1:0];
                    6'd7:  sc_result_s = $signed(i_dat_B) >>> i_dat_A[SH_W-1:0];
                    6'd8:  sc_result_s = i_dat_A;
                    6'd16: sc_result_s = hi_q;
                    6'd18: sc_result_s = lo_q;
                    6'd24: begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
                    6'd25: is_mul_s = 1'b1;
                    6'd26: begin is_div_s = 1'b1; is_signed_s = 1'b1; end
                    6'd27: is_div_s = 1'b1;
                    6'd32: begin
                        sc_result_s = sum_s;
                        sc_ovf_s    = (i_dat_A[WIDTH-1] == i_dat_B[WIDTH-1]) &&
                                      (sum_s[WIDTH-1] != i_dat_A[WIDTH-1]);
                    end
                    6'd33: sc_result_s = sum_s;
                    6'd34: begin
                        sc_result_s = diff_s;
                        sc_ovf_s    = (i_dat_A[WIDTH-1] != i_dat_B[WIDTH-1]) &&
                                      (diff_s[WIDTH-1] != i_dat_A[WIDTH-1]);
                    end
                    6'd35: sc_result_s = diff_s;
                    6'd36: sc_result_s = i_dat_A & i_dat_B;
                    6'd37: sc_result_s = i_dat_A | i_dat_B;
                    6'd38: sc_result_s = i_dat_A ^ i_dat_B;
                    6'd39: sc_result_s = ~(i_dat_A | i_dat_B);
                    6'd42: sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(i_dat_A) < $signed(i_dat_B))};
                    6'd43: sc_result_s = {{(WIDTH-1){1'b0}}, (i_dat_A < i_dat_B)};
                    default: illegal_s = 1'b1;
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // One iteration of the shift-add multiplier or restoring divider.
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift_s = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        div_ge_s    = ~div_diff_s[WIDTH];
        if (state_q == S_MUL) begin
            work_hi_d = mul_sum_s[WIDTH:1];
            work_lo_d = {mul_sum_s[0], work_lo_q[WIDTH-1:1]};
        end else begin
            work_hi_d = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], div_ge_s};
        end
    end

    // Sign fix-up: product negated as a whole; quotient and remainder separately.
    always_comb begin
        prod_s = {work_hi_q, work_lo_q};
        if (op_mul_q) begin
            if (neg_lo_q) begin
                prod_s = -prod_s;
            end else begin
                prod_s = {work_hi_q, work_lo_q};
            end
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else begin
            fix_lo_s = neg_lo_q ? -work_lo_q : work_lo_q;
            fix_hi_s = neg_hi_q ? -work_hi_q : work_hi_q;
        end
    end

    // Control FSM with registered result, flags, HI/LO and iteration state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            opnd_q      <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            op_signed_q <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            op_mul_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                    if (i_con_Valid) begin
                        if (is_mul_s || is_div_s) begin
                            state_q     <= is_mul_s ? S_MUL : S_DIV;
                            op_a_q      <= i_dat_A;
                            op_b_q      <= i_dat_B;
                            op_mul_q    <= is_mul_s;
                            op_signed_q <= is_signed_s;
                            neg_lo_q    <= is_signed_s && (i_dat_A[WIDTH-1] ^ i_dat_B[WIDTH-1]);
                            neg_hi_q    <= is_signed_s && i_dat_A[WIDTH-1];
                            cnt_q       <= '0;
                        end else begin
                            valid_q   <= 1'b1;
                            result_q  <= sc_result_s;
                            zero_q    <= (sc_result_s == '0);
                            ovf_q     <= sc_ovf_s;
                            illegal_q <= illegal_s;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt_q == '0) begin
                        // Divide by zero finishes here without iterating.
                        if ((state_q == S_DIV) && (op_b_q == '0)) begin
                            lo_q      <= '1;
                            hi_q      <= op_a_q;
                            result_q  <= '1;
                            zero_q    <= 1'b0;
                            ovf_q     <= 1'b0;
                            illegal_q <= 1'b0;
                            valid_q   <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            work_hi_q <= '0;
                            work_lo_q <= mag(op_a_q, op_signed_q);
                            opnd_q    <= mag(op_b_q, op_signed_q);
                            cnt_q     <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        work_hi_q <= work_hi_d;
                        work_lo_q <= work_lo_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                S_FIX: begin
                    hi_q      <= fix_hi_s;
                    lo_q      <= fix_lo_s;
                    result_q  <= fix_lo_s;
                    zero_q    <= (fix_lo_s == '0);
                    ovf_q     <= 1'b0;
                    illegal_q <= 1'b0;
                    valid_q   <= 1'b1;
                    state_q   <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_con_Ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign o_con_Valid   = valid_q;
    assign o_dat_Result  = result_q;
    assign o_con_Zero    = zero_q;
    assign o_con_Ovf     = ovf_q;
    assign o_con_Illegal = illegal_q;
    assign o_dat_Hi      = hi_q;
    assign o_dat_Lo      = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_in;
    logic        rdy;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a_in, b_in;
    logic [4:0]  shamt;
    logic        v_out, zero, ovf, illegal;
    logic [31:0] result, hi, lo;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SH_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_con_Valid(v_in), .o_con_Ready(rdy),
        .i_con_AluOp(aluop), .i_con_FuncCode(funct),
        .i_dat_A(a_in), .i_dat_B(b_in), .i_dat_Shamt(shamt),
        .o_con_Valid(v_out), .o_dat_Result(result), .o_con_Zero(zero),
        .o_con_Ovf(ovf), .o_con_Illegal(illegal),
        .o_dat_Hi(hi), .o_dat_Lo(lo)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
        logic        eovf;
    } vec_t;

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        v_in = 1'b1; aluop = op; funct = fn; a_in = a; b_in = b; shamt = sh;
    endtask

    // Waits (bounded) for the completion pulse; returns cycles since accept.
    task automatic run_multi(input int budget, output int lat, output bit rdy_low_ok);
        lat = -1;
        rdy_low_ok = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) v_in = 1'b0;
            if (v_out === 1'b1) begin
                lat = k;
                break;
            end
            if (rdy !== 1'b0) rdy_low_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v_in = 1'b0; aluop = 2'b00; funct = 6'd0;
        a_in = 32'd0; b_in = 32'd0; shamt = 5'd0;
        repeat (2) @(negedge clk);
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", rdy); end
        tests_run++; if (v_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", v_out); end
        tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        tests_run++; if ({zero, ovf, illegal} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {zero, ovf, illegal}); end
        tests_run++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(2'b00, 6'd0, 32'd5, 32'd7, 5'd0);
        @(negedge clk); v_in = 1'b0;
        tests_run++; if (v_out !== 1'b1) begin fails++; $display("FAIL add_valid: got %b want 1", v_out); end
        tests_run++; if (result !== 32'd12) begin fails++; $display("FAIL add_result: got %h want 0000000c", result); end
        tests_run++; if (zero !== 1'b0) begin fails++; $display("FAIL add_zero: got %b want 0", zero); end
        drive(2'b01, 6'd0, 32'd7, 32'd7, 5'd0);
        @(negedge clk); v_in = 1'b0;
        tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL sub_result: got %h want 0", result); end
        tests_run++; if (zero !== 1'b1) begin fails++; $display("FAIL sub_zero: got %b want 1", zero); end
        @(negedge clk);
        tests_run++; if (v_out !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", v_out); end
    endtask

    task automatic test_back_to_back();
        vec_t vecs [10];
        vecs[0] = '{2'b10, 6'd3,  32'h0,        32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[1] = '{2'b10, 6'd42, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0};
        vecs[2] = '{2'b10, 6'd43, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0};
        vecs[3] = '{2'b10, 6'd32, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b1};
        vecs[4] = '{2'b10, 6'd33, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b0};
        vecs[5] = '{2'b10, 6'd34, 32'h8000_0000, 32'd1,         5'd0,  32'h7FFF_FFFF, 1'b1};
        vecs[6] = '{2'b10, 6'd4,  32'd4,         32'd3,         5'd0,  32'h30,        1'b0};
        vecs[7] = '{2'b10, 6'd39, 32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{2'b10, 6'd2,  32'd0,         32'h8000_0000, 5'd31, 32'd1,         1'b0};
        vecs[9] = '{2'b10, 6'd8,  32'h1234,      32'd9,         5'd0,  32'h1234,      1'b0};
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                tests_run++; if (v_out !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want 1", i-1, v_out); end
                tests_run++; if (result !== vecs[i-1].exp) begin fails++; $display("FAIL b2b_result[%0d]: got %h want %h", i-1, result, vecs[i-1].exp); end
                tests_run++; if (ovf !== vecs[i-1].eovf) begin fails++; $display("FAIL b2b_ovf[%0d]: got %b want %b", i-1, ovf, vecs[i-1].eovf); end
                tests_run++; if (zero !== (vecs[i-1].exp == 32'd0)) begin fails++; $display("FAIL b2b_zero[%0d]: got %b", i-1, zero); end
                tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", i-1, rdy); end
            end
            if (i < 10) drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].sh);
            else v_in = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_mult();
        int lat;
        bit ok;
        drive(2'b10, 6'd24, 32'hFFFF_FFFD, 32'd5, 5'd0);
        run_multi(60, lat, ok);
        tests_run++; if (lat !== 35) begin fails++; $display("FAIL mult_latency: got %0d want 35", lat); end
        tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL mult_ready_low: got %b want 1", ok); end
        tests_run++; if (lo !== 32'hFFFF_FFF1) begin fails++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
        tests_run++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        tests_run++; if (result !== 32'hFFFF_FFF1) begin fails++; $display("FAIL mult_result: got %h want fffffff1", result); end
        tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL mult_done_ready: got %b want 1", rdy); end
        drive(2'b10, 6'd16, 32'd0, 32'd0, 5'd0);
        @(negedge clk); v_in = 1'b0;
        tests_run++; if (v_out !== 1'b1) begin fails++; $display("FAIL mfhi_valid: got %b want 1", v_out); end
        tests_run++; if (result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mfhi_result: got %h want ffffffff", result); end
        drive(2'b10, 6'd25, 32'hFFFF_FFFF, 32'd2, 5'd0);
        run_multi(60, lat, ok);
        tests_run++; if (lat !== 35) begin fails++; $display("FAIL multu_latency: got %0d want 35", lat); end
        tests_run++; if ({hi, lo} !== 64'h1_FFFF_FFFE) begin fails++; $display("FAIL multu_hilo: got %h want 00000001fffffffe", {hi, lo}); end
        drive(2'b10, 6'd18, 32'd0, 32'd0, 5'd0);
        @(negedge clk); v_in = 1'b0;
        tests_run++; if (result !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mflo_result: got %h want fffffffe", result); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat;
        bit ok;
        drive(2'b10, 6'd26, 32'hFFFF_FFF9, 32'd2, 5'd0);
        run_multi(60, lat, ok);
        tests_run++; if (lat !== 35) begin fails++; $display("FAIL div_latency: got %0d want 35", lat); end
        tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL div_ready_low: got %b want 1", ok); end
        tests_run++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        tests_run++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        drive(2'b10, 6'd27, 32'd9, 32'd0, 5'd0);
        run_multi(60, lat, ok);
        tests_run++; if (lat !== 2) begin fails++; $display("FAIL div0_latency: got %0d want 2", lat); end
        tests_run++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        tests_run++; if (hi !== 32'd9) begin fails++; $display("FAIL div0_hi: got %h want 00000009", hi); end
        tests_run++; if (result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_result: got %h want ffffffff", result); end
        drive(2'b10, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        run_multi(60, lat, ok);
        tests_run++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL divmin_hilo: got %h want 0000000080000000", {hi, lo}); end
        drive(2'b10, 6'd27, 32'd100, 32'd7, 5'd0);
        run_multi(60, lat, ok);
        tests_run++; if ({hi, lo} !== {32'd2, 32'd14}) begin fails++; $display("FAIL divu_hilo: got %h want 000000020000000e", {hi, lo}); end
        tests_run++; if (zero !== 1'b0) begin fails++; $display("FAIL divu_zero: got %b want 0", zero); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        drive(2'b10, 6'd1, 32'd55, 32'd66, 5'd3);
        @(negedge clk); v_in = 1'b0;
        tests_run++; if ({v_out, illegal} !== 2'b11) begin fails++; $display("FAIL ill_funct_flags: got %b want 11", {v_out, illegal}); end
        tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL ill_funct_result: got %h want 0", result); end
        tests_run++; if (zero !== 1'b1) begin fails++; $display("FAIL ill_funct_zero: got %b want 1", zero); end
        drive(2'b11, 6'd24, 32'd3, 32'd4, 5'd0);
        @(negedge clk); v_in = 1'b0;
        tests_run++; if ({v_out, illegal, ovf} !== 3'b110) begin fails++; $display("FAIL ill_aluop_flags: got %b want 110", {v_out, illegal, ovf}); end
        tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL ill_aluop_result: got %h want 0", result); end
        @(negedge clk);
        tests_run++; if ({rdy, v_out} !== 2'b10) begin fails++; $display("FAIL ill_no_start: got %b want 10", {rdy, v_out}); end
        tests_run++; if ({hi, lo} !== {32'd2, 32'd14}) begin fails++; $display("FAIL ill_hilo: got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        drive(2'b10, 6'd27, 32'd1000, 32'd3, 5'd0);
        @(negedge clk); v_in = 1'b0;
        repeat (9) @(negedge clk);
        tests_run++; if (rdy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", rdy); end
        rst_n = 1'b0;
        #1;
        tests_run++; if ({rdy, v_out} !== 2'b10) begin fails++; $display("FAIL rst_mid_ctl: got %b want 10", {rdy, v_out}); end
        tests_run++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (v_out === 1'b1) pulses++;
        end
        tests_run++; if (pulses !== 0) begin fails++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mult();
        test_div();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
